mips_uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the processor's data-memory bus, in parallel with the RAM: same Address / WriteData / MemWrite / MemRead signals.
- Processor stores bytes to a data address; they queue in a small FIFO and are serialised 8N1 on TxD.
- A status word is readable at a second address so software can poll before storing.
- Top-level muxes ReadData into the load path when Hit=1.

---
 rtl/mips_uart_tx_mmio.sv | 175 +++++++++++++++++
 tb/tb_mips_uart_tx_mmio.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_uart_tx_mmio.sv
// mips_uart_tx_mmio: data-bus mapped UART transmitter with a byte FIFO (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mips_uart_tx_mmio #(
   parameter int unsigned BAUD_DIV    = 434,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [31:0] DATA_ADDR   = 32'h1001_0024,
   parameter logic [31:0] STATUS_ADDR = 32'h1001_0028
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        TxD,
   output logic        TxBusy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_TOP = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic hit_data, hit_stat, full, empty;
   logic pop, push_req, push, baud_zero;
   logic [31:0] status;
   logic unused_wdata;

   assign hit_data  = (Address == DATA_ADDR);
   assign hit_stat  = (Address == STATUS_ADDR);
   assign Hit       = hit_data || hit_stat;
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign pop       = (state_q == IDLE) && !empty;
   assign push_req  = MemWrite && hit_data;
   // A full FIFO still accepts a byte when the head leaves this cycle
   assign push      = push_req && (!full || pop);
   assign baud_zero = (baud_q == '0);
   assign unused_wdata = ^WriteData[31:8];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (MemWrite && hit_stat && WriteData[3])
         ovf_d = 1'b0;
      if (push_req && !push)
         ovf_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = 1'b1;
      if (state_q != IDLE)
         baud_d = baud_zero ? BAUD_TOP : baud_q - BW'(1);
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = START;
               baud_d  = BAUD_TOP;
               shift_d = fifo_q[rd_ptr_q];
            end
         end
         START: begin
            txd_d = 1'b0;
            if (baud_zero) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            txd_d = shift_q[bit_q];
            if (baud_zero) begin
               if (bit_q == 3'd7)
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               else
                  bit_d = bit_q + 3'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            txd_d = ^shift_q;
            if (baud_zero)
               state_d = STOP;
         end
`endif
         STOP: begin
            txd_d = 1'b1;
            if (baud_zero)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (count_d != '0) || (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr_q] <= WriteData[7:0];
   end

   always_comb begin
      status      = '0;
      status[0]   = full;
      status[1]   = empty;
      status[2]   = (state_q != IDLE);
      status[3]   = ovf_q;
      status[8:4] = 5'(count_q);
`ifdef UART_TX_PARITY_EN
      status[9]   = 1'b1;
`endif
   end

   assign ReadData = (MemRead && hit_stat) ? status : 32'h0;
   assign TxD      = txd_q;
   assign TxBusy   = busy_q;
endmodule

// File: tb/tb_mips_uart_tx_mmio.sv
// tb_mips_uart_tx_mmio: directed checks of the MMIO UART transmitter.
// A serial monitor decodes TxD frames; define UART_TX_PARITY_EN for 8E1.
module tb_mips_uart_tx_mmio;
   localparam int BD = 4;
   localparam logic [31:0] DA = 32'h1001_0024;
   localparam logic [31:0] SA = 32'h1001_0028;
`ifdef UART_TX_PARITY_EN
   localparam int STOPK = 10;
   localparam logic [31:0] PB = 32'h200;
`else
   localparam int STOPK = 9;
   localparam logic [31:0] PB = 32'h0;
`endif
   localparam int BUSY_END = BD * (STOPK + 1) + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address, WriteData, ReadData;
   logic        MemWrite, MemRead, Hit, TxD, TxBusy;

   int checks = 0;
   int errors = 0;
   int ferr = 0;
   int mon_cnt = 0;
   logic [7:0] mon_sh;
   logic       mon_par;
   logic [7:0] rxq[$];
   logic       parq[$];

   always #5 clk = ~clk;

   mips_uart_tx_mmio #(
      .BAUD_DIV(BD), .FIFO_DEPTH(4),
      .DATA_ADDR(DA), .STATUS_ADDR(SA)
   ) dut (
      .clk(clk), .reset(reset), .Address(Address),
      .WriteData(WriteData), .MemWrite(MemWrite),
      .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
      .TxD(TxD), .TxBusy(TxBusy)
   );

   // Frame decoder: samples each bit at its middle
   always @(negedge clk) begin
      int k;
      if (!reset) begin
         mon_cnt = 0;
      end else if (mon_cnt == 0) begin
         if (TxD == 1'b0) mon_cnt = 1;
      end else begin
         mon_cnt++;
         if (mon_cnt >= BD / 2 + 1 &&
             (mon_cnt - BD / 2 - 1) % BD == 0) begin
            k = (mon_cnt - BD / 2 - 1) / BD;
            if (k == 0 && TxD !== 1'b0) ferr++;
            if (k >= 1 && k <= 8) mon_sh[k-1] = TxD;
            if (k == 9 && STOPK == 10) mon_par = TxD;
            if (k == STOPK) begin
               if (TxD !== 1'b1) ferr++;
               rxq.push_back(mon_sh);
               parq.push_back(mon_par);
               mon_cnt = 0;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
   endtask

   task automatic rd_status(output logic [31:0] v);
      Address = SA;
      MemRead = 1'b1;
      #1;
      v = ReadData;
      MemRead = 1'b0;
      Address = '0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((TxBusy || mon_cnt != 0) && n < lim) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(n < lim), 32'd1);
   endtask

   initial begin
      logic [31:0] st;
      reset = 1'b0; Address = '0; WriteData = '0;
      MemWrite = 1'b0; MemRead = 1'b0;
      tick(3);
      reset = 1'b1;
      chk("rst_txd", 32'(TxD), 32'd1);
      chk("rst_busy", 32'(TxBusy), 32'd0);
      rd_status(st);
      chk("rst_status", st, 32'h2 | PB);

      Address = DA; #1;
      chk("hit_data", 32'(Hit), 32'd1);
      MemRead = 1'b1; #1;
      chk("rd_data_addr", ReadData, 32'h0);
      MemRead = 1'b0;
      Address = SA; #1;
      chk("hit_stat", 32'(Hit), 32'd1);
      Address = 32'h1001_0020; #1;
      chk("hit_other", 32'(Hit), 32'd0);
      Address = '0;

      sw(DA, 32'hFFFF_FF55);
      chk("busy_rise", 32'(TxBusy), 32'd1);
      chk("lat_n0", 32'(TxD), 32'd1);
      tick();
      chk("lat_n1", 32'(TxD), 32'd1);
      tick();
      chk("lat_n2", 32'(TxD), 32'd0);
      tick(BUSY_END - 3);
      chk("busy_hold", 32'(TxBusy), 32'd1);
      tick();
      chk("busy_fall", 32'(TxBusy), 32'd0);
      wait_idle(200);
      chk("rx55_n", rxq.size(), 32'd1);
      chk("rx55", 32'(rxq.pop_front()), 32'h55);
      void'(parq.pop_front());

      for (int i = 1; i <= 5; i++) sw(DA, 32'(i));
      sw(DA, 32'h06);
      rd_status(st);
      chk("ovf_status", st, 32'h4D | PB);
      sw(SA, 32'h8);
      rd_status(st);
      chk("ovf_clear", st, 32'h45 | PB);
      tick(BUSY_END - 6);
      rd_status(st);
      chk("idle_gap", st, 32'h41 | PB);
      sw(DA, 32'h07);
      rd_status(st);
      chk("push_full_pop", st, 32'h45 | PB);
      wait_idle(2000);
      chk("rx_burst_n", rxq.size(), 32'd6);
      for (int i = 1; i <= 6; i++) begin
         logic [7:0] e;
         e = (i == 6) ? 8'h07 : 8'(i);
         chk("rx_burst", 32'(rxq.pop_front()), 32'(e));
      end
      parq.delete();

      sw(DA, 32'hA5);
      sw(DA, 32'h3C);
      tick(17);
      chk("mid_bit3", 32'(TxD), 32'd0);
      rd_status(st);
      chk("mid_status", st, 32'h14 | PB);
      reset = 1'b0;
      tick();
      chk("abort_txd", 32'(TxD), 32'd1);
      chk("abort_busy", 32'(TxBusy), 32'd0);
      rd_status(st);
      chk("abort_status", st, 32'h2 | PB);
      reset = 1'b1;
      tick(80);
      chk("abort_no_rx", rxq.size(), 32'd0);
      chk("abort_idle", 32'(TxD), 32'd1);

      sw(DA, 32'h07);
      sw(DA, 32'h03);
      wait_idle(500);
      chk("rx_pair_n", rxq.size(), 32'd2);
      chk("rx_07", 32'(rxq.pop_front()), 32'h07);
      chk("rx_03", 32'(rxq.pop_front()), 32'h03);
`ifdef UART_TX_PARITY_EN
      chk("par_07", 32'(parq.pop_front()), 32'd1);
      chk("par_03", 32'(parq.pop_front()), 32'd0);
`endif
      chk("frame_err", 32'(ferr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
